// File: rtl/div_seq_pkg.sv
// Shared types for the sequential restoring divider: FSM encoding and
// a helper that sizes the step counter.
package div_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/div_seq_if.sv
// Request/result bundle between the ALU sequencer (master) and div_seq (slave).
interface div_seq_if #(parameter int WIDTH = 32);
   logic                 start;
   logic                 is_signed;
   logic [WIDTH-1:0]     RegA;
   logic [WIDTH-1:0]     RegB;
   logic                 busy;
   logic                 done;
   logic                 div_by_zero;
   logic                 overflow;
   logic [2*WIDTH-1:0]   Z;

   modport master (output start, is_signed, RegA, RegB,
                   input  busy, done, div_by_zero, overflow, Z);
   modport slave  (input  start, is_signed, RegA, RegB,
                   output busy, done, div_by_zero, overflow, Z);
endinterface

// File: rtl/div_seq_step.sv
// One combinational restoring-division step on magnitudes:
// shift {A,Q} left, trial-subtract M, keep or restore.
module div_step #(
   parameter int W = 32
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] q_i,
   input  logic [W-1:0] m_i,
   output logic [W-1:0] a_o,
   output logic [W-1:0] q_o
);
   logic [W:0] sh, diff;
   logic       ge;

   // A < M on entry, so the shifted value fits W+1 bits and a negative
   // trial result always shows up in the top bit.
   assign sh   = {a_i, q_i[W-1]};
   assign diff = sh - {1'b0, m_i};
   assign ge   = ~diff[W];
   assign a_o  = ge ? diff[W-1:0] : sh[W-1:0];
   assign q_o  = {q_i[W-2:0], ge};
endmodule

// File: rtl/div_seq.sv
// Multi-cycle signed/unsigned restoring divider with start/done handshake.
// Z = {remainder, quotient}; magnitudes are divided, signs applied in FIX.
module div_seq
   import div_seq_pkg::*;
#(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic    clock,
   input  logic    clear_n,
   div_seq_if.slave bus
);
   localparam int N  = WIDTH / BITS_PER_CYCLE;
   localparam int CW = cnt_w(N);

   state_e               state_q, state_d;
   logic [CW-1:0]        cnt_q;
   logic [WIDTH-1:0]     a_q, q_q, m_q;
   logic                 neg_q_q, neg_r_q, dbz_q, ovf_q;
   logic [2*WIDTH-1:0]   z_q, z_d;
   logic                 res_dbz_q, res_ovf_q;
   logic                 busy_o, done_o;

   logic                 accept, b_zero, sa, sb, is_ovf;
   logic [WIDTH-1:0]     abs_a, abs_b, r_res, q_res;
   logic [WIDTH-1:0]     a_nxt, q_nxt;

   assign accept = bus.start && (state_q == ST_IDLE || state_q == ST_DONE);
   assign b_zero = (bus.RegB == '0);
   assign sa     = bus.is_signed & bus.RegA[WIDTH-1];
   assign sb     = bus.is_signed & bus.RegB[WIDTH-1];
   assign abs_a  = sa ? -bus.RegA : bus.RegA;
   assign abs_b  = sb ? -bus.RegB : bus.RegB;
   assign is_ovf = bus.is_signed && (bus.RegA == {1'b1, {(WIDTH-1){1'b0}}})
                   && (bus.RegB == '1);

   for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
      logic [WIDTH-1:0] a_in, q_in, a_out, q_out;
      if (i == 0) begin : g_first
         assign a_in = a_q;
         assign q_in = q_q;
      end else begin : g_next
         assign a_in = g_step[i-1].a_out;
         assign q_in = g_step[i-1].q_out;
      end
      div_step #(.W(WIDTH)) u_step (
         .a_i(a_in), .q_i(q_in), .m_i(m_q), .a_o(a_out), .q_o(q_out)
      );
   end
   assign a_nxt = g_step[BITS_PER_CYCLE-1].a_out;
   assign q_nxt = g_step[BITS_PER_CYCLE-1].q_out;

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE, ST_DONE: state_d = accept ? (b_zero ? ST_FIX : ST_CALC) : ST_IDLE;
         ST_CALC:          if (cnt_q == '0) state_d = ST_FIX;
         ST_FIX:           state_d = ST_DONE;
         default:          state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy_o = (state_q == ST_CALC) || (state_q == ST_FIX);
      done_o = (state_q == ST_DONE);
   end

   // Divide-by-zero parks the raw dividend in Q so FIX can return it as R.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         cnt_q   <= '0;
         a_q     <= '0;
         q_q     <= '0;
         m_q     <= '0;
         neg_q_q <= 1'b0;
         neg_r_q <= 1'b0;
         dbz_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (accept) begin
         cnt_q   <= CW'(N-1);
         a_q     <= '0;
         q_q     <= b_zero ? bus.RegA : abs_a;
         m_q     <= abs_b;
         neg_q_q <= sa ^ sb;
         neg_r_q <= sa;
         dbz_q   <= b_zero;
         ovf_q   <= is_ovf;
      end else if (state_q == ST_CALC) begin
         cnt_q   <= cnt_q - CW'(1);
         a_q     <= a_nxt;
         q_q     <= q_nxt;
      end
   end

   always_comb begin
      r_res = neg_r_q ? -a_q : a_q;
      q_res = neg_q_q ? -q_q : q_q;
      z_d   = dbz_q ? {q_q, {WIDTH{1'b1}}} : {r_res, q_res};
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         z_q       <= '0;
         res_dbz_q <= 1'b0;
         res_ovf_q <= 1'b0;
      end else if (state_q == ST_FIX) begin
         z_q       <= z_d;
         res_dbz_q <= dbz_q;
         res_ovf_q <= ovf_q;
      end
   end

   assign bus.busy        = busy_o;
   assign bus.done        = done_o;
   assign bus.Z           = z_q;
   assign bus.div_by_zero = res_dbz_q;
   assign bus.overflow    = res_ovf_q;
endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: two instances (1 and 4 bits/cycle) checked every cycle
// against a latency-countdown model with arithmetic reference results.
module tb_div_seq;
   localparam int W = 32;

   logic clock   = 1'b0;
   logic clear_n = 1'b1;
   int   n_chk   = 0;
   int   n_fail  = 0;

   always #5 clock = ~clock;

   div_seq_if #(.WIDTH(W)) bus1 ();
   div_seq_if #(.WIDTH(W)) bus4 ();

   div_seq #(.WIDTH(W), .BITS_PER_CYCLE(1)) u_dut1 (.clock(clock), .clear_n(clear_n), .bus(bus1));
   div_seq #(.WIDTH(W), .BITS_PER_CYCLE(4)) u_dut4 (.clock(clock), .clear_n(clear_n), .bus(bus4));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // {div_by_zero, overflow, R, Q}
   function automatic logic [65:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sg);
      longint sa, sb, q, r;
      logic   ov;
      if (b == 32'd0) return {1'b1, 1'b0, a, 32'hFFFF_FFFF};
      if (sg) begin
         sa = longint'(signed'(a));
         sb = longint'(signed'(b));
      end else begin
         sa = longint'(a);
         sb = longint'(b);
      end
      q  = sa / sb;
      r  = sa % sb;
      ov = sg && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      return {1'b0, ov, r[31:0], q[31:0]};
   endfunction

   function automatic int lat_of(input int k, input logic [31:0] b);
      if (b == 32'd0) return 2;
      return (k == 0 ? W / 1 : W / 4) + 2;
   endfunction

   // model: per-DUT countdown to the done cycle plus held results
   int          m_left [2] = '{0, 0};
   logic [65:0] m_pend [2];
   logic [63:0] m_z    [2] = '{64'd0, 64'd0};
   logic        m_dbz  [2] = '{1'b0, 1'b0};
   logic        m_ovf  [2] = '{1'b0, 1'b0};
   logic        m_done [2] = '{1'b0, 1'b0};
   logic        in_st  [2];
   logic        in_sg  [2];
   logic [31:0] in_a   [2];
   logic [31:0] in_b   [2];

   assign in_st[0] = bus1.start;  assign in_sg[0] = bus1.is_signed;
   assign in_a[0]  = bus1.RegA;   assign in_b[0]  = bus1.RegB;
   assign in_st[1] = bus4.start;  assign in_sg[1] = bus4.is_signed;
   assign in_a[1]  = bus4.RegA;   assign in_b[1]  = bus4.RegB;

   always @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         for (int k = 0; k < 2; k++) begin
            m_left[k] <= 0;
            m_done[k] <= 1'b0;
            m_z[k]    <= '0;
            m_dbz[k]  <= 1'b0;
            m_ovf[k]  <= 1'b0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (m_left[k] == 0 && in_st[k]) begin
               m_pend[k] <= ref_div(in_a[k], in_b[k], in_sg[k]);
               m_left[k] <= lat_of(k, in_b[k]) - 1;
               m_done[k] <= 1'b0;
            end else if (m_left[k] == 1) begin
               m_left[k] <= 0;
               m_done[k] <= 1'b1;
               m_z[k]    <= m_pend[k][63:0];
               m_dbz[k]  <= m_pend[k][65];
               m_ovf[k]  <= m_pend[k][64];
            end else begin
               if (m_left[k] > 0) m_left[k] <= m_left[k] - 1;
               m_done[k] <= 1'b0;
            end
         end
      end
   end

   always @(negedge clock) begin
      chk("busy1", bus1.busy, m_left[0] != 0);
      chk("done1", bus1.done, m_done[0]);
      chk("Z1",    bus1.Z,    m_z[0]);
      chk("dbz1",  bus1.div_by_zero, m_dbz[0]);
      chk("ovf1",  bus1.overflow,    m_ovf[0]);
      chk("busy4", bus4.busy, m_left[1] != 0);
      chk("done4", bus4.done, m_done[1]);
      chk("Z4",    bus4.Z,    m_z[1]);
      chk("dbz4",  bus4.div_by_zero, m_dbz[1]);
      chk("ovf4",  bus4.overflow,    m_ovf[1]);
   end

   task automatic drive(input int k, input logic st, input logic sg, input logic [31:0] a, input logic [31:0] b);
      if (k == 0) begin
         bus1.start = st; bus1.is_signed = sg; bus1.RegA = a; bus1.RegB = b;
      end else begin
         bus4.start = st; bus4.is_signed = sg; bus4.RegA = a; bus4.RegB = b;
      end
   endtask

   function automatic logic done_of(input int k);
      return (k == 0) ? bus1.done : bus4.done;
   endfunction

   function automatic logic busy_of(input int k);
      return (k == 0) ? bus1.busy : bus4.busy;
   endfunction

   // start is held for one edge; operands are scrambled right after capture
   task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b, input logic sg,
                         output int lat, output int bcnt);
      drive(k, 1'b1, sg, a, b);
      lat  = 0;
      bcnt = 0;
      do begin
         @(posedge clock); #1;
         if (lat == 0) drive(k, 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
         lat++;
         if (busy_of(k)) bcnt++;
      end while (!done_of(k) && lat < 200);
   endtask

   task automatic rand_op(input int k);
      logic [31:0] a, b;
      int          lat, bcnt, gap;
      case ($urandom_range(0, 9))
         0:       b = 32'd0;
         1:       b = 32'hFFFF_FFFF;
         2:       b = 32'd1;
         3:       b = $urandom_range(1, 15);
         4:       b = -($urandom_range(1, 15));
         default: b = $urandom;
      endcase
      case ($urandom_range(0, 5))
         0:       a = 32'h8000_0000;
         1:       a = 32'd0;
         2:       a = $urandom_range(0, 200);
         default: a = $urandom;
      endcase
      gap = $urandom_range(0, 3);
      repeat (gap) begin @(posedge clock); #1; end
      run_op(k, a, b, 1'($urandom_range(0, 1)), lat, bcnt);
      chk("rnd_lat", lat, lat_of(k, b));
   endtask

   int lat, bcnt, dcnt;

   initial begin
      drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
      drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
      #2 clear_n = 1'b0;
      #1;
      chk("rst_busy", bus1.busy, 0);
      chk("rst_done", bus1.done, 0);
      chk("rst_Z",    bus1.Z,    0);
      repeat (2) @(negedge clock);
      clear_n = 1'b1;
      @(posedge clock); #1;

      run_op(0, 32'd100, 32'd7, 1'b0, lat, bcnt);
      chk("t1_lat",  lat,  34);
      chk("t1_busy", bcnt, 33);
      chk("t1_Z",    bus1.Z, {32'd2, 32'd14});

      run_op(0, 32'hFFFF_FFF9, 32'd2, 1'b1, lat, bcnt);
      chk("t2_nd_Z", bus1.Z, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      run_op(0, 32'd7, 32'hFFFF_FFFE, 1'b1, lat, bcnt);
      chk("t2_dn_Z", bus1.Z, {32'd1, 32'hFFFF_FFFD});
      run_op(0, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, lat, bcnt);
      chk("t2_nn_Z", bus1.Z, {32'hFFFF_FFFF, 32'd3});

      run_op(0, 32'd5, 32'd0, 1'b0, lat, bcnt);
      chk("t3_dz_lat", lat, 2);
      chk("t3_dz_Z",   bus1.Z, {32'd5, 32'hFFFF_FFFF});
      chk("t3_dz_flg", bus1.div_by_zero, 1);
      run_op(0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat, bcnt);
      chk("t3_ov_lat", lat, 34);
      chk("t3_ov_Z",   bus1.Z, {32'd0, 32'h8000_0000});
      chk("t3_ov_flg", bus1.overflow, 1);
      chk("t3_ov_dz",  bus1.div_by_zero, 0);

      drive(0, 1'b1, 1'b0, 32'd1000, 32'd7);
      @(posedge clock); #1;
      drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
      repeat (9) begin @(posedge clock); #1; end
      clear_n = 1'b0;
      #1;
      chk("t4_busy", bus1.busy, 0);
      chk("t4_Z",    bus1.Z, 0);
      chk("t4_ovf",  bus1.overflow, 0);
      @(negedge clock);
      clear_n = 1'b1;
      dcnt = 0;
      repeat (40) begin
         @(posedge clock); #1;
         if (bus1.done) dcnt++;
      end
      chk("t4_nodone", dcnt, 0);
      run_op(0, 32'd9, 32'd3, 1'b0, lat, bcnt);
      chk("t4_lat", lat, 34);
      chk("t4_Z9",  bus1.Z, {32'd0, 32'd3});

      drive(0, 1'b1, 1'b0, 32'd100, 32'd7);
      lat = 0;
      do begin
         @(posedge clock); #1;
         lat++;
         if (lat == 1) drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
         if (lat == 5) drive(0, 1'b1, 1'b1, 32'd50, 32'd5);
         if (lat == 6) drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
         if (lat == 20) chk("t6_Zhold", bus1.Z, {32'd0, 32'd3});
      end while (!bus1.done && lat < 200);
      chk("t6_lat", lat, 34);
      chk("t6_Z",   bus1.Z, {32'd2, 32'd14});

      run_op(1, 32'hFFFF_FFFF, 32'd3, 1'b0, lat, bcnt);
      chk("t5_lat", lat, 10);
      chk("t5_Z",   bus4.Z, {32'd0, 32'h5555_5555});
      run_op(1, 32'd8, 32'd2, 1'b0, lat, bcnt);
      chk("t5_b2b_lat", lat, 10);
      chk("t5_b2b_Z",   bus4.Z, {32'd0, 32'd4});

      for (int i = 0; i < 600; i++)  rand_op(0);
      for (int i = 0; i < 1500; i++) rand_op(1);

      repeat (2) @(posedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
